// File: rtl/tetris_play_ctrl.sv
// Tetris game-play sequencer: owns the occupancy grid and the falling piece, and runs
// spawn, gravity, moves, a bit-serial collision check, locking, line clearing and game-over.
module tetris_play_ctrl #(
  parameter int COLS = 10,
  parameter int ROWS = 30,
  parameter int CELL = 16,
  parameter int X0   = 240
) (
  input  logic                 iVGA_CLK,
  input  logic                 iRST_n,
  input  logic                 tick,
  input  logic                 key_en,
  input  logic [7:0]           key_in,
  input  logic [2:0]           piece_type,
  output logic [COLS*ROWS-1:0] grid,
  output logic [9:0]           ref_x,
  output logic [9:0]           ref_y,
  output logic [15:0]          piece_mask,
  output logic [2:0]           state,
  output logic [7:0]           lines_cleared,
  output logic                 game_over
);

  localparam int N = COLS * ROWS;
  localparam logic [4:0] COLS5 = 5'(COLS);
  localparam logic [6:0] ROWS7 = 7'(ROWS);
  localparam logic [8:0] COLS9 = 9'(COLS);
  localparam logic [8:0] N9    = 9'(N);
  localparam logic [7:0] K_LEFT  = 8'h6b;
  localparam logic [7:0] K_RIGHT = 8'h74;
  localparam logic [7:0] K_DOWN  = 8'h72;

  typedef enum logic [2:0] {
    S_SPAWN = 3'd0, S_WAIT = 3'd1, S_CHECK = 3'd2,
    S_LOCK  = 3'd3, S_CLEAR = 3'd4, S_OVER = 3'd5
  } state_t;
  typedef enum logic [1:0] {M_SPAWN, M_MOVE, M_DOWN} mode_t;

  state_t             r_state;
  mode_t              r_mode;
  logic [N-1:0]       r_grid;
  logic signed [4:0]  r_col;
  logic [4:0]         r_row;
  logic signed [4:0]  r_cand_col;
  logic [5:0]         r_cand_row;
  logic [3:0]         r_idx;
  logic               r_coll;
  logic               r_tick_pend;
  logic [15:0]        r_mask;
  logic [9:0]         r_ref_x;
  logic [9:0]         r_ref_y;
  logic [7:0]         r_lines;
  logic [4:0]         r_scan;
  logic               r_game_over;

  function automatic logic [15:0] f_shape(input logic [2:0] t);
    case (t)
      3'd1:    return 16'h000F;
      3'd2:    return 16'h0027;
      3'd3:    return 16'h0063;
      3'd4:    return 16'h0036;
      default: return 16'h0033;
    endcase
  endfunction

  function automatic logic [9:0] f_ref_x(input logic signed [4:0] c);
    return 10'(X0 + int'(c) * CELL);
  endfunction

  function automatic logic [9:0] f_ref_y(input logic [4:0] r);
    return 10'(int'(r) * CELL);
  endfunction

  // Collision test for the single mask cell r_idx at the candidate position
  logic signed [5:0] w_cc;
  logic [6:0]        w_cr;
  logic [8:0]        w_gidx;
  logic              w_oob;
  logic              w_hit;
  logic              w_coll_all;

  assign w_cc       = $signed({r_cand_col[4], r_cand_col} + {4'b0, r_idx[1:0]});
  assign w_cr       = {1'b0, r_cand_row} + {5'b0, r_idx[3:2]};
  assign w_gidx     = 9'(w_cr) * COLS9 + {4'b0, w_cc[4:0]};
  assign w_oob      = w_cc[5] || (w_cc[4:0] >= COLS5) || (w_cr >= ROWS7);
  assign w_hit      = r_mask[r_idx] && (w_oob || ((w_gidx < N9) && r_grid[w_gidx]));
  assign w_coll_all = r_coll | w_hit;

  // Every shape occupies mask column 0, so a committed col is never negative
  logic [N-1:0] w_part [4];
  logic [N-1:0] w_lock_grid;
  logic [N-1:0] w_shift;
  logic [ROWS-1:0] w_full;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_lock
      assign w_part[g] = N'(r_mask[g*4 +: 4]) <<
                         (({4'b0, r_row} + 9'(g)) * COLS9 + {5'b0, r_col[3:0]});
    end
    for (g = 0; g < ROWS; g++) begin : g_row
      assign w_full[g] = &r_grid[g*COLS +: COLS];
      if (g == 0) begin : g_top
        assign w_shift[0 +: COLS] = '0;
      end else begin : g_body
        assign w_shift[g*COLS +: COLS] = (5'(g) <= r_scan) ? r_grid[(g-1)*COLS +: COLS]
                                                          : r_grid[g*COLS +: COLS];
      end
    end
  endgenerate

  assign w_lock_grid = r_grid | w_part[0] | w_part[1] | w_part[2] | w_part[3];

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_state     <= S_SPAWN;
      r_mode      <= M_SPAWN;
      r_grid      <= '0;
      r_col       <= 5'sd3;
      r_row       <= '0;
      r_cand_col  <= 5'sd3;
      r_cand_row  <= '0;
      r_idx       <= '0;
      r_coll      <= 1'b0;
      r_tick_pend <= 1'b0;
      r_mask      <= '0;
      r_ref_x     <= f_ref_x(5'sd3);
      r_ref_y     <= '0;
      r_lines     <= '0;
      r_scan      <= '0;
      r_game_over <= 1'b0;
    end else begin
      case (r_state)
        S_SPAWN: begin
          r_mask     <= f_shape(piece_type);
          r_col      <= 5'sd3;
          r_row      <= '0;
          r_ref_x    <= f_ref_x(5'sd3);
          r_ref_y    <= '0;
          r_cand_col <= 5'sd3;
          r_cand_row <= '0;
          r_mode     <= M_SPAWN;
          r_idx      <= '0;
          r_coll     <= 1'b0;
          r_state    <= S_CHECK;
        end
        S_WAIT: begin
          if (key_en && (key_in == K_LEFT || key_in == K_RIGHT)) begin
            r_cand_col <= (key_in == K_LEFT) ? r_col - 5'sd1 : r_col + 5'sd1;
            r_cand_row <= {1'b0, r_row};
            r_mode     <= M_MOVE;
            r_idx      <= '0;
            r_coll     <= 1'b0;
            r_state    <= S_CHECK;
          end else if ((key_en && key_in == K_DOWN) || r_tick_pend) begin
            r_cand_col  <= r_col;
            r_cand_row  <= {1'b0, r_row} + 6'd1;
            r_mode      <= M_DOWN;
            r_idx       <= '0;
            r_coll      <= 1'b0;
            r_tick_pend <= 1'b0;
            r_state     <= S_CHECK;
          end
        end
        S_CHECK: begin
          r_idx  <= r_idx + 4'd1;
          r_coll <= w_coll_all;
          if (r_idx == 4'd15) begin
            if (!w_coll_all) begin
              r_col   <= r_cand_col;
              r_row   <= r_cand_row[4:0];
              r_ref_x <= f_ref_x(r_cand_col);
              r_ref_y <= f_ref_y(r_cand_row[4:0]);
              r_state <= S_WAIT;
            end else begin
              case (r_mode)
                M_MOVE:  r_state <= S_WAIT;
                M_DOWN:  r_state <= S_LOCK;
                default: begin
                  r_state     <= S_OVER;
                  r_game_over <= 1'b1;
                end
              endcase
            end
          end
        end
        S_LOCK: begin
          r_grid  <= w_lock_grid;
          r_scan  <= 5'(ROWS - 1);
          r_state <= S_CLEAR;
        end
        // A full row is collapsed and the same row index is re-examined next cycle
        S_CLEAR: begin
          if (w_full[r_scan]) begin
            r_grid  <= w_shift;
            r_lines <= r_lines + 8'd1;
          end else if (r_scan == 5'd0) begin
            r_state <= S_SPAWN;
          end else begin
            r_scan <= r_scan - 5'd1;
          end
        end
        default: ;
      endcase
      if (tick && r_state != S_OVER) r_tick_pend <= 1'b1;
    end
  end

  assign grid          = r_grid;
  assign ref_x         = r_ref_x;
  assign ref_y         = r_ref_y;
  assign piece_mask    = r_mask;
  assign state         = r_state;
  assign lines_cleared = r_lines;
  assign game_over     = r_game_over;

endmodule

// File: tb/tb_tetris_play_ctrl.sv
// Bench for tetris_play_ctrl: directed scenarios plus a random game checked against
// a move-by-move model of the Tetris rules.
module tb_tetris_play_ctrl;
  logic         iVGA_CLK = 1'b0;
  logic         iRST_n = 1'b0;
  logic         tick = 1'b0;
  logic         key_en = 1'b0;
  logic [7:0]   key_in = 8'h00;
  logic [2:0]   piece_type = 3'd0;
  logic [299:0] grid;
  logic [9:0]   ref_x, ref_y;
  logic [15:0]  piece_mask;
  logic [2:0]   state;
  logic [7:0]   lines_cleared;
  logic         game_over;

  tetris_play_ctrl dut (
    .iVGA_CLK(iVGA_CLK), .iRST_n(iRST_n), .tick(tick), .key_en(key_en), .key_in(key_in),
    .piece_type(piece_type), .grid(grid), .ref_x(ref_x), .ref_y(ref_y),
    .piece_mask(piece_mask), .state(state), .lines_cleared(lines_cleared),
    .game_over(game_over)
  );

  always #5 iVGA_CLK = ~iVGA_CLK;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: piece position in cells, grid as a 2D array
  bit          m_grid [30][10];
  int          m_col, m_row, m_lines;
  logic [15:0] m_mask;
  bit          m_over;

  function automatic logic [15:0] shape_of(input int t);
    case (t)
      1: return 16'h000F;
      2: return 16'h0027;
      3: return 16'h0063;
      4: return 16'h0036;
      default: return 16'h0033;
    endcase
  endfunction

  function automatic bit fits(input int col, input int row);
    for (int i = 0; i < 16; i++) begin
      if (m_mask[i]) begin
        int c = col + i % 4;
        int r = row + i / 4;
        if (c < 0 || c >= 10 || r >= 30) return 1'b0;
        if (m_grid[r][c]) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  function automatic logic [299:0] model_grid();
    logic [299:0] v = '0;
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 10; c++)
        if (m_grid[r][c]) v = v | (300'(1) << (r * 10 + c));
    return v;
  endfunction

  function automatic logic [47:0] model_vec();
    return {(m_over ? 3'd5 : 3'd1), 10'(240 + m_col * 16), 10'(m_row * 16), m_mask,
            8'(m_lines), m_over};
  endfunction

  task automatic m_reset();
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 10; c++) m_grid[r][c] = 1'b0;
    m_col = 3; m_row = 0; m_lines = 0; m_mask = '0; m_over = 1'b0;
  endtask

  task automatic m_spawn();
    m_mask = shape_of(int'(piece_type));
    m_col = 3;
    m_row = 0;
    if (!fits(3, 0)) m_over = 1'b1;
  endtask

  task automatic m_move(input int d);
    if (!m_over && fits(m_col + d, m_row)) m_col += d;
  endtask

  task automatic m_down(output bit locked, output int nfull);
    locked = 1'b0;
    nfull = 0;
    if (m_over) return;
    if (fits(m_col, m_row + 1)) begin
      m_row++;
      return;
    end
    locked = 1'b1;
    for (int i = 0; i < 16; i++)
      if (m_mask[i]) m_grid[m_row + i / 4][m_col + i % 4] = 1'b1;
    for (int r = 29; r >= 0; ) begin
      bit full = 1'b1;
      for (int c = 0; c < 10; c++) full &= m_grid[r][c];
      if (full) begin
        for (int k = r; k > 0; k--) m_grid[k] = m_grid[k - 1];
        for (int c = 0; c < 10; c++) m_grid[0][c] = 1'b0;
        nfull++;
        m_lines = (m_lines + 1) % 256;
      end else begin
        r--;
      end
    end
    m_spawn();
  endtask

  task automatic pulse_key(input logic [7:0] k);
    @(negedge iVGA_CLK);
    key_en = 1'b1;
    key_in = k;
    @(negedge iVGA_CLK);
    key_en = 1'b0;
  endtask

  task automatic pulse_tick();
    @(negedge iVGA_CLK);
    tick = 1'b1;
    @(negedge iVGA_CLK);
    tick = 1'b0;
  endtask

  task automatic settle();
    int b = 0;
    @(negedge iVGA_CLK);
    while (!(state == 3'd1 || state == 3'd5) && b < 300) begin
      @(negedge iVGA_CLK);
      b++;
    end
    if (b >= 300) begin
      n_chk++;
      $display("FAIL settle: state=%0d still busy after %0d cycles, need 1 or 5", state, b);
    end
  endtask

  // kind: 0 left, 1 right, 2 down key, 3 tick, 4 ignored key
  task automatic apply(input int kind, output bit locked);
    int nf;
    locked = 1'b0;
    case (kind)
      0: begin pulse_key(8'h6b); m_move(-1); end
      1: begin pulse_key(8'h74); m_move(1); end
      2: begin pulse_key(8'h72); m_down(locked, nf); end
      3: begin pulse_tick(); m_down(locked, nf); end
      default: pulse_key(8'h1c);
    endcase
    settle();
  endtask

  task automatic drop_piece();
    bit lk = 1'b0;
    int g = 0;
    while (!lk && !m_over && g < 40) begin
      apply(2, lk);
      g++;
    end
  endtask

  task automatic lock_to_spawn(output int cnt);
    int b = 0;
    cnt = -1;
    while (state != 3'd3 && b < 60) begin
      @(negedge iVGA_CLK);
      b++;
    end
    if (state == 3'd3) begin
      cnt = 0;
      while (state != 3'd0 && cnt < 100) begin
        @(negedge iVGA_CLK);
        cnt++;
      end
    end
  endtask

  task automatic do_reset(input logic [2:0] t);
    tick = 1'b0;
    key_en = 1'b0;
    piece_type = t;
    iRST_n = 1'b0;
    @(negedge iVGA_CLK);
    @(negedge iVGA_CLK);
    iRST_n = 1'b1;
    m_reset();
    m_spawn();
  endtask

  localparam logic [47:0] RESET_VEC = {3'd0, 10'd288, 10'd0, 16'h0000, 8'd0, 1'b0};

  task automatic test_reset();
    tick = 1'b0; key_en = 1'b0; piece_type = 3'd0; iRST_n = 1'b0;
    @(negedge iVGA_CLK);
    n_chk++;
    if ({state, ref_x, ref_y, piece_mask, lines_cleared, game_over} !== RESET_VEC)
      $display("FAIL reset_outputs: got %h want %h",
               {state, ref_x, ref_y, piece_mask, lines_cleared, game_over}, RESET_VEC);
    else n_pass++;
    n_chk++;
    if (grid !== 300'd0) $display("FAIL reset_grid: got %h want 0", grid); else n_pass++;
    iRST_n = 1'b1;
    m_reset();
    m_spawn();
    repeat (16) @(negedge iVGA_CLK);
    n_chk++;
    if (state !== 3'd2) $display("FAIL spawn_edge16: state=%0d want 2", state); else n_pass++;
    @(negedge iVGA_CLK);
    n_chk++;
    if ({state, ref_x, ref_y, piece_mask} !== {3'd1, 10'd288, 10'd0, 16'h0033} || grid !== 300'd0)
      $display("FAIL spawn_edge17: st=%0d x=%0d y=%0d mask=%h want 1 288 0 0033",
               state, ref_x, ref_y, piece_mask);
    else n_pass++;
  endtask

  task automatic test_square_drop();
    bit lk;
    int nf, cnt;
    logic [299:0] exp_g;
    do_reset(3'd0);
    settle();
    for (int i = 0; i < 28; i++) apply(3, lk);
    n_chk++;
    if (ref_y !== 10'd448) $display("FAIL square_28_ticks: ref_y=%0d want 448", ref_y);
    else n_pass++;
    pulse_tick();
    m_down(lk, nf);
    lock_to_spawn(cnt);
    n_chk++;
    if (cnt != 31) $display("FAIL square_lock_latency: %0d edges want 31", cnt); else n_pass++;
    settle();
    exp_g = (300'(1) << 283) | (300'(1) << 284) | (300'(1) << 293) | (300'(1) << 294);
    n_chk++;
    if (grid !== exp_g || grid !== model_grid())
      $display("FAIL square_lock_grid: got %h want %h", grid, exp_g);
    else n_pass++;
    n_chk++;
    if (state !== 3'd1 || ref_y !== 10'd0)
      $display("FAIL square_respawn: st=%0d y=%0d want 1 0", state, ref_y);
    else n_pass++;
  endtask

  task automatic test_bar_moves();
    bit lk;
    do_reset(3'd1);
    settle();
    @(negedge iVGA_CLK);
    key_en = 1'b1;
    key_in = 8'h6b;
    @(negedge iVGA_CLK);
    key_en = 1'b0;
    repeat (15) @(negedge iVGA_CLK);
    n_chk++;
    if (ref_x !== 10'd288 || state !== 3'd2)
      $display("FAIL move_latency_early: x=%0d st=%0d want 288 2", ref_x, state);
    else n_pass++;
    @(negedge iVGA_CLK);
    m_move(-1);
    n_chk++;
    if (ref_x !== 10'd272 || state !== 3'd1)
      $display("FAIL move_latency_k16: x=%0d st=%0d want 272 1", ref_x, state);
    else n_pass++;
    apply(0, lk);
    apply(0, lk);
    n_chk++;
    if (ref_x !== 10'd240) $display("FAIL bar_3_lefts: x=%0d want 240", ref_x); else n_pass++;
    apply(0, lk);
    n_chk++;
    if (ref_x !== 10'd240 || state !== 3'd1)
      $display("FAIL bar_left_wall: x=%0d st=%0d want 240 1", ref_x, state);
    else n_pass++;
    for (int i = 0; i < 6; i++) apply(1, lk);
    n_chk++;
    if (ref_x !== 10'd336) $display("FAIL bar_6_rights: x=%0d want 336", ref_x); else n_pass++;
    apply(1, lk);
    n_chk++;
    if (ref_x !== 10'd336 || ref_x !== 10'(240 + m_col * 16))
      $display("FAIL bar_right_wall: x=%0d want 336", ref_x);
    else n_pass++;
  endtask

  task automatic test_line_clear();
    bit lk;
    int nf, cnt;
    logic [299:0] exp_g;
    do_reset(3'd1);
    settle();
    for (int i = 0; i < 3; i++) apply(0, lk);
    drop_piece();
    apply(1, lk);
    piece_type = 3'd0;
    drop_piece();
    for (int i = 0; i < 5; i++) apply(1, lk);
    for (int i = 0; i < 28; i++) apply(2, lk);
    pulse_key(8'h72);
    m_down(lk, nf);
    lock_to_spawn(cnt);
    n_chk++;
    if (cnt != 32) $display("FAIL clear_latency: %0d edges want 32", cnt); else n_pass++;
    settle();
    exp_g = (300'(1) << 298) | (300'(1) << 299);
    n_chk++;
    if (lines_cleared !== 8'd1) $display("FAIL clear_lines: got %0d want 1", lines_cleared);
    else n_pass++;
    n_chk++;
    if (grid !== exp_g || grid !== model_grid())
      $display("FAIL clear_grid: got %h want %h", grid, exp_g);
    else n_pass++;
  endtask

  task automatic test_game_over();
    bit lk;
    int g = 0;
    int nf;
    logic [299:0] g0;
    logic [9:0] x0;
    do_reset(3'd0);
    settle();
    while (!m_over && g < 40) begin
      drop_piece();
      g++;
    end
    n_chk++;
    if (game_over !== 1'b1 || state !== 3'd5 || !m_over)
      $display("FAIL over_reached: go=%b st=%0d want 1 5", game_over, state);
    else n_pass++;
    n_chk++;
    if (grid !== model_grid()) $display("FAIL over_grid: got %h want %h", grid, model_grid());
    else n_pass++;
    g0 = grid;
    x0 = ref_x;
    for (int k = 0; k < 5; k++) apply(k == 4 ? 3 : k, lk);
    repeat (20) @(negedge iVGA_CLK);
    n_chk++;
    if (grid !== g0 || ref_x !== x0 || state !== 3'd5)
      $display("FAIL over_frozen: st=%0d x=%0d want 5 %0d", state, ref_x, x0);
    else n_pass++;
    // reset asserted between clock edges while CHECK is running
    iRST_n = 1'b0;
    @(negedge iVGA_CLK);
    iRST_n = 1'b1;
    repeat (5) @(negedge iVGA_CLK);
    n_chk++;
    if (state !== 3'd2) $display("FAIL mid_check_pre: st=%0d want 2", state); else n_pass++;
    #2 iRST_n = 1'b0;
    #1;
    n_chk++;
    if ({state, ref_x, ref_y, piece_mask, lines_cleared, game_over} !== RESET_VEC || grid !== 300'd0)
      $display("FAIL mid_check_reset: got %h want %h",
               {state, ref_x, ref_y, piece_mask, lines_cleared, game_over}, RESET_VEC);
    else n_pass++;
    @(negedge iVGA_CLK);
    iRST_n = 1'b1;
    m_reset();
    m_spawn();
    settle();
    for (int i = 0; i < 28; i++) apply(2, lk);
    pulse_key(8'h72);
    m_down(lk, nf);
    g = 0;
    while (state != 3'd4 && g < 60) begin
      @(negedge iVGA_CLK);
      g++;
    end
    repeat (3) @(negedge iVGA_CLK);
    n_chk++;
    if (state !== 3'd4 || grid !== model_grid())
      $display("FAIL mid_clear_pre: st=%0d want 4, grid %h want %h", state, grid, model_grid());
    else n_pass++;
    #2 iRST_n = 1'b0;
    #1;
    n_chk++;
    if ({state, ref_x, ref_y, piece_mask, lines_cleared, game_over} !== RESET_VEC || grid !== 300'd0)
      $display("FAIL mid_clear_reset: st=%0d grid=%h want 0 0", state, grid);
    else n_pass++;
    @(negedge iVGA_CLK);
    iRST_n = 1'b1;
    m_reset();
    m_spawn();
    settle();
  endtask

  task automatic test_tick_and_key();
    bit lk;
    int nf;
    do_reset(3'd1);
    settle();
    @(negedge iVGA_CLK);
    tick = 1'b1;
    key_en = 1'b1;
    key_in = 8'h6b;
    @(negedge iVGA_CLK);
    tick = 1'b0;
    key_en = 1'b0;
    m_move(-1);
    repeat (16) @(negedge iVGA_CLK);
    n_chk++;
    if (state !== 3'd1 || ref_x !== 10'd272 || ref_y !== 10'd0)
      $display("FAIL combo_left_first: st=%0d x=%0d y=%0d want 1 272 0", state, ref_x, ref_y);
    else n_pass++;
    @(negedge iVGA_CLK);
    n_chk++;
    if (state !== 3'd2) $display("FAIL combo_tick_pending: st=%0d want 2", state); else n_pass++;
    m_down(lk, nf);
    repeat (16) @(negedge iVGA_CLK);
    n_chk++;
    if (state !== 3'd1 || ref_y !== 10'(m_row * 16) || ref_y !== 10'd16 || ref_x !== 10'd272)
      $display("FAIL combo_down: st=%0d x=%0d y=%0d want 1 272 16", state, ref_x, ref_y);
    else n_pass++;
    repeat (40) @(negedge iVGA_CLK);
    n_chk++;
    if (state !== 3'd1 || ref_y !== 10'd16)
      $display("FAIL combo_no_extra: st=%0d y=%0d want 1 16", state, ref_y);
    else n_pass++;
  endtask

  task automatic test_random_game();
    bit lk;
    int kind;
    do_reset(3'($urandom_range(0, 7)));
    settle();
    for (int it = 0; it < 300; it++) begin
      piece_type = 3'($urandom_range(0, 7));
      kind = $urandom_range(0, 9);
      apply(kind < 2 ? 0 : kind < 4 ? 1 : kind < 7 ? 2 : kind < 9 ? 3 : 4, lk);
      n_chk++;
      if ({state, ref_x, ref_y, piece_mask, lines_cleared, game_over} !== model_vec())
        $display("FAIL rand_outputs it=%0d: got %h want %h", it,
                 {state, ref_x, ref_y, piece_mask, lines_cleared, game_over}, model_vec());
      else n_pass++;
      n_chk++;
      if (grid !== model_grid())
        $display("FAIL rand_grid it=%0d: got %h want %h", it, grid, model_grid());
      else n_pass++;
      if (m_over) begin
        do_reset(3'($urandom_range(0, 7)));
        settle();
      end
    end
  endtask

  initial begin
    test_reset();
    test_square_drop();
    test_bar_moves();
    test_line_clear();
    test_game_over();
    test_tick_and_key();
    test_random_game();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tetris_play_ctrl.md
# tetris_play_ctrl

Game-play sequencer for the Tetris VGA datapath. It owns the 10x30 occupancy grid and the falling piece's position and shape, and runs spawn, gravity, left/right moves, collision checking, locking, line clearing and game-over. Its outputs feed the piece and static-block renderers: piece pixel origin ref_x/ref_y, piece bitmap piece_mask, and grid.

## Interface
- COLS, 10, playfield columns
- ROWS, 30, playfield rows
- CELL, 16, cell size in pixels
- X0, 240, pixel x of column 0
- iVGA_CLK  in  1  clock
- iRST_n  in  1  reset; asynchronous, active-low
- tick  in  1  gravity pulse, one cycle wide
- key_en  in  1  key_in valid strobe
- key_in  in  8  scancode: 8'h6b left, 8'h74 right, 8'h72 down; other codes ignored
- piece_type  in  3  next piece (LFSR-derived), sampled in SPAWN
- grid  out  300  occupancy; bit = row*COLS+col, row 0 at top
- ref_x  out  10  X0 + col*CELL
- ref_y  out  10  row*CELL
- piece_mask  out  16  4x4 piece bitmap; bit = r*4+c, relative to (row,col)
- state  out  3  FSM state code
- lines_cleared  out  8  total rows cleared, wraps modulo 256
- game_over  out  1  high in OVER

## Operation
- Shape table, indexed by piece_type:
  - 0 square 16'h0033
  - 1 bar 16'h000F
  - 2 T 16'h0027
  - 3 Z 16'h0063
  - 4 S 16'h0036
  - 5-7 map to square
- States (code):
  - SPAWN(0): latch the mask, col=3, row=0; candidate=(3,0), mode=spawn; go to CHECK.
  - WAIT(1):
    - key_en with 6b/74 → candidate col∓1, mode=move, CHECK.
    - Otherwise key_en with 72, or tick_pend → candidate row+1, mode=down, clear tick_pend, CHECK.
  - CHECK(2): index i=0..15, one bit per cycle. Collision when mask[i] is set and any of:
    - candidate col + (i%4) < 0
    - candidate col + (i%4) ≥ COLS
    - candidate row + i/4 ≥ ROWS
    - the target grid bit is set

    After i=15:
    - No collision → commit the candidate → WAIT.
    - Collision with mode=move → WAIT, position unchanged.
    - Collision with mode=down → LOCK.
    - Collision with mode=spawn → OVER.
  - LOCK(3): OR all mask cells into grid at the current (row,col) in one cycle; set scan row r=ROWS-1; go to CLEAR.
  - CLEAR(4): one row per cycle.
    - Row r full → in one cycle, rows 1..r take the row above, row 0 clears, lines_cleared+1; r is held so the same row is rechecked.
    - Row r not full → r-1.
    - After row 0 is found not full → SPAWN.
  - OVER(5): terminal. Ignore all inputs until reset.
- Candidate col is a signed 5-bit value, so a left move from col 0 yields -1 and collides.
- tick_pend:
  - Set by tick in any state except OVER.
  - Cleared when WAIT consumes it.
  - Extra ticks while pending are merged into one.
- key_en outside WAIT is dropped.

## Timing
- Reset values:
  - grid=0, lines_cleared=0, game_over=0, tick_pend=0
  - col=3, row=0, ref_x=288, ref_y=0
  - piece_mask=0, state=SPAWN
- The first edge after reset release performs SPAWN.
- CHECK always takes exactly 16 cycles. The commit/LOCK/OVER decision is made on the edge that ends i=15.
- Move latency: key sampled on WAIT edge k → ref_x/ref_y update on edge k+16 → WAIT again at k+16.
- Spawn to WAIT: 17 edges.
- Lock to next SPAWN: 1 + 30 + (number of full rows) edges.
- Tick and key_en in the same WAIT cycle: the key is serviced, the tick stays pending and is serviced in the next WAIT.
- ref_x, ref_y and piece_mask are registered and change only on commit or SPAWN.
- grid changes only in LOCK or CLEAR.
- Asynchronous reset mid-CHECK or mid-CLEAR returns immediately to reset values. No partial grid update survives.

## Test plan
- Reset, piece_type=0 → after 17 edges:
  - state=1, ref_x=288, ref_y=0, piece_mask=16'h0033, grid=0
- Square, 28 ticks → ref_y=448. 29th tick → lock, grid bits 283, 284, 293, 294 set; then SPAWN and WAIT.
- Bar (type 1):
  - 3 lefts → ref_x=240; 4th left → unchanged.
  - 6 rights from col 0 → ref_x=336; 7th right → unchanged.
- Bars dropped at cols 0 and 4, then a square at col 8:
  - Row 29 is cleared, lines_cleared=1.
  - grid has only bits 298 and 299 set.
- Stack squares at col 3 until the spawn check collides:
  - game_over=1, state=5.
  - Further ticks and keys leave grid and ref_x unchanged.
  - iRST_n pulsed low mid-CHECK → all reset values restored.
- tick and key_en=6b in the same WAIT cycle:
  - Left commits first.
  - The down move follows in the next CHECK, ref_y+16, with no extra tick applied.
